mult_div: RTL

Sequential signed multiply/divide unit for the multicycle MIPS core, sitting beside the ALU and fed from the A/B operand registers. It serves the MULT and DIV instructions: the control unit pulses a start, holds the FSM in a wait state while `busy` is high, and later moves HI or LO to the register file for MFHI and MFLO. Multiply uses radix-2 Booth; divide uses signed restoring division with MIPS truncate-toward-zero semantics.

---
 rtl/mips_pkg.sv | 16 +
 rtl/div_step.sv | 32 +++
 rtl/mult_div.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core types: mult/div FSM states and funct codes
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MULT_RUN = 2'd1,
    DIV_RUN  = 2'd2,
    DONE     = 2'd3
  } md_state_t;

  localparam logic [5:0] FUNCT_MULT = 6'h18;
  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_MFHI = 6'h10;
  localparam logic [5:0] FUNCT_MFLO = 6'h12;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one unsigned restoring-division step on magnitudes
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             unused_trial_bit;

  // r < d on entry, so the shifted remainder is below 2d and the kept
  // remainder always fits back into WIDTH bits.
  always_comb begin
    shifted = {r, q[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, d};
    if (trial[WIDTH+1]) begin
      r_nxt = shifted[WIDTH-1:0];
      q_nxt = {q[WIDTH-2:0], 1'b0};
    end else begin
      r_nxt = trial[WIDTH-1:0];
      q_nxt = {q[WIDTH-2:0], 1'b1};
    end
  end

  assign unused_trial_bit = trial[WIDTH];

endmodule

// File: rtl/mult_div.sv
// rtl/mult_div.sv - sequential signed multiply (radix-2 Booth) / divide (restoring) unit
module mult_div
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH) + 1;

  md_state_t        state, state_nxt;
  logic             dz_nxt;
  logic [CW-1:0]    cnt;
  logic             last_iter;

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH:0]   acc;
  logic [WIDTH:0]     booth_sum;
  logic [2*WIDTH:0]   acc_nxt;

  logic [WIDTH-1:0] rem, quo, dvsr;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic             q_neg, r_neg;

  assign last_iter = (cnt == CW'(WIDTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // DONE accepts a new start just like IDLE, giving the 34-cycle back-to-back period.
  always_comb begin
    state_nxt = state;
    dz_nxt    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (state == DONE) state_nxt = IDLE;
        if (start_mult) begin
          state_nxt = MULT_RUN;
        end else if (start_div) begin
          if (B_in == '0) begin
            state_nxt = DONE;
            dz_nxt    = 1'b1;
          end else begin
            state_nxt = DIV_RUN;
          end
        end
      end
      MULT_RUN, DIV_RUN: if (last_iter) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Booth add/sub is done one bit wider so that +2^(WIDTH-1) partial sums
  // (from subtracting the most negative multiplicand) keep their true sign.
  always_comb begin
    case (acc[1:0])
      2'b01:   booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]} + {mcand[WIDTH-1], mcand};
      2'b10:   booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]} - {mcand[WIDTH-1], mcand};
      default: booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    endcase
    acc_nxt = {booth_sum, acc[WIDTH:1]};
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .r     (rem),
    .q     (quo),
    .d     (dvsr),
    .r_nxt (rem_nxt),
    .q_nxt (quo_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      mcand    <= '0;
      acc      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      busy     <= (state_nxt == MULT_RUN) || (state_nxt == DIV_RUN);
      done     <= (state_nxt == DONE);
      div_zero <= dz_nxt;
      case (state)
        IDLE, DONE: begin
          cnt <= '0;
          if (state_nxt == MULT_RUN) begin
            mcand <= A_in;
            acc   <= {{WIDTH{1'b0}}, B_in, 1'b0};
          end else if (state_nxt == DIV_RUN) begin
            rem   <= '0;
            quo   <= A_in[WIDTH-1] ? -A_in : A_in;
            dvsr  <= B_in[WIDTH-1] ? -B_in : B_in;
            q_neg <= A_in[WIDTH-1] ^ B_in[WIDTH-1];
            r_neg <= A_in[WIDTH-1];
          end
        end
        MULT_RUN: begin
          if (last_iter) begin
            HI <= acc[2*WIDTH:WIDTH+1];
            LO <= acc[WIDTH:1];
          end else begin
            acc <= acc_nxt;
            cnt <= cnt + CW'(1);
          end
        end
        DIV_RUN: begin
          if (last_iter) begin
            HI <= r_neg ? -rem : rem;
            LO <= q_neg ? -quo : quo;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + CW'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
